// File: rtl/ct_ifu_btb_tag_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ct_ifu_btb_tag_ctrl_pkg
// Shared constants and types for the BTB tag-array controller.
//   IDX_W      : set index width (512 sets)
//   TAG_W      : stored tag width
//   ENTRY_W    : one way entry, {valid, tag}
//   STARVE_MAX : cycles a buffered write may wait behind lookups
//   state_e    : controller FSM states
// ---------------------------------------------------------------------------
package ct_ifu_btb_tag_ctrl_pkg;

   localparam int IDX_W      = 9;
   localparam int TAG_W      = 10;
   localparam int ENTRY_W    = 11;
   localparam int STARVE_MAX = 8;
   localparam int NUM_WAYS   = 4;

   typedef enum logic [1:0] {
      INIT_INV = 2'd0,
      IDLE     = 2'd1,
      INV      = 2'd2
   } state_e;

endpackage

// File: rtl/ct_ifu_btb_tag_wbuf.sv
// ---------------------------------------------------------------------------
// ct_ifu_btb_tag_wbuf
// One-entry write buffer for BTB tag updates plus its starvation counter.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   flush_i            : drop any held entry (invalidate sweep running)
//   load_i             : capture index_i/tag_i/way_i (only when empty)
//   issue_i            : held entry is written to the array this cycle
//   full_o             : entry held
//   index_o/tag_o/way_o: held entry
//   starve_o           : entry has been held for STARVE_MAX cycles
// ---------------------------------------------------------------------------
module ct_ifu_btb_tag_wbuf
   import ct_ifu_btb_tag_ctrl_pkg::STARVE_MAX;
#(
   parameter int IDX_W = 9,
   parameter int TAG_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             load_i,
   input  logic             issue_i,
   input  logic [IDX_W-1:0] index_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic [1:0]       way_i,
   output logic             full_o,
   output logic [IDX_W-1:0] index_o,
   output logic [TAG_W-1:0] tag_o,
   output logic [1:0]       way_o,
   output logic             starve_o
);

   localparam int CNT_W = $clog2(STARVE_MAX);

   logic             full_q, full_d;
   logic [CNT_W-1:0] age_q, age_d;
   logic [IDX_W-1:0] index_q;
   logic [TAG_W-1:0] tag_q;
   logic [1:0]       way_q;

   // age_q counts full cycles already elapsed, so the STARVE_MAX-th full
   // cycle is the one where age_q reaches STARVE_MAX-1.
   assign starve_o = full_q && (age_q == CNT_W'(STARVE_MAX - 1));

   always_comb begin
      full_d = full_q;
      age_d  = age_q;
      if (flush_i || issue_i) begin
         full_d = 1'b0;
         age_d  = '0;
      end else if (load_i) begin
         full_d = 1'b1;
         age_d  = '0;
      end else if (full_q && !starve_o) begin
         age_d  = age_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q  <= 1'b0;
         age_q   <= '0;
         index_q <= '0;
         tag_q   <= '0;
         way_q   <= '0;
      end else begin
         full_q <= full_d;
         age_q  <= age_d;
         if (load_i && !flush_i) begin
            index_q <= index_i;
            tag_q   <= tag_i;
            way_q   <= way_i;
         end
      end
   end

   assign full_o  = full_q;
   assign index_o = index_q;
   assign tag_o   = tag_q;
   assign way_o   = way_q;

endmodule

// File: rtl/ct_ifu_btb_tag_ctrl.sv
// ---------------------------------------------------------------------------
// ct_ifu_btb_tag_ctrl
// Controller for the 4-way BTB tag SRAM: power-on / requested invalidate
// sweep, lookup with one-cycle tag compare, buffered single-way updates.
// Ports:
//   forever_cpuclk, cpurst          : clock, synchronous active-high reset
//   lkup_vld/index/tag, lkup_rdy    : lookup request and acceptance
//   upd_vld/index/tag/way, upd_rdy  : update request, ready = buffer empty
//   inv_req, inv_busy, inv_done     : full invalidate control/status
//   rslt_vld/hit/hit_way            : lookup result, one cycle after accept
//   btb_tag_*                       : SRAM interface (active-low cen/wen)
// ---------------------------------------------------------------------------
module ct_ifu_btb_tag_ctrl #(
   parameter int IDX_W = ct_ifu_btb_tag_ctrl_pkg::IDX_W,
   parameter int TAG_W = ct_ifu_btb_tag_ctrl_pkg::TAG_W
) (
   input  logic                     forever_cpuclk,
   input  logic                     cpurst,
   input  logic                     lkup_vld,
   input  logic [IDX_W-1:0]         lkup_index,
   input  logic [TAG_W-1:0]         lkup_tag,
   output logic                     lkup_rdy,
   input  logic                     upd_vld,
   input  logic [IDX_W-1:0]         upd_index,
   input  logic [TAG_W-1:0]         upd_tag,
   input  logic [1:0]               upd_way,
   output logic                     upd_rdy,
   input  logic                     inv_req,
   output logic                     inv_busy,
   output logic                     inv_done,
   output logic                     rslt_vld,
   output logic                     rslt_hit,
   output logic [3:0]               rslt_hit_way,
   output logic [9:0]               btb_index,
   output logic                     btb_tag_cen_b,
   output logic                     btb_tag_clk_en,
   output logic [2*(TAG_W+1)-1:0]   btb_tag_din,
   output logic [3:0]               btb_tag_wen,
   input  logic [4*(TAG_W+1)-1:0]   btb_tag_dout
);
   import ct_ifu_btb_tag_ctrl_pkg::*;

   localparam int ENT_W = TAG_W + 1;

   state_e           state_q;
   logic [IDX_W-1:0] sweep_cnt_q;
   logic             inv_done_q;
   logic             rslt_vld_q;
   logic [TAG_W-1:0] lkup_tag_q;

   logic             buf_full, buf_starve;
   logic [IDX_W-1:0] buf_index;
   logic [TAG_W-1:0] buf_tag;
   logic [1:0]       buf_way;

   logic             sweeping, idle_op, lkup_acc, wr_issue, upd_load;
   logic [IDX_W-1:0] arr_index;
   logic [3:0]       hit_way;

   assign sweeping = (state_q != IDLE);
   // Reset is folded in so the array sees no access in a reset cycle.
   assign idle_op  = (state_q == IDLE) && !cpurst;

   // A waiting write takes priority when starved or when the lookup would
   // read the very set it is about to modify.
   assign lkup_rdy = idle_op && !(buf_full && (buf_starve || (buf_index == lkup_index)));
   assign lkup_acc = lkup_vld && lkup_rdy;
   assign wr_issue = idle_op && buf_full && !lkup_acc;
   assign upd_rdy  = idle_op && !buf_full;
   assign upd_load = upd_vld && upd_rdy;

   ct_ifu_btb_tag_wbuf #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_wbuf (
      .clk_i    (forever_cpuclk),
      .rst_i    (cpurst),
      .flush_i  (sweeping),
      .load_i   (upd_load),
      .issue_i  (wr_issue),
      .index_i  (upd_index),
      .tag_i    (upd_tag),
      .way_i    (upd_way),
      .full_o   (buf_full),
      .index_o  (buf_index),
      .tag_o    (buf_tag),
      .way_o    (buf_way),
      .starve_o (buf_starve)
   );

   // SRAM request mux: sweep write, lookup read, or buffered single-way write.
   always_comb begin
      btb_tag_cen_b = 1'b1;
      btb_tag_wen   = 4'b1111;
      btb_tag_din   = '0;
      arr_index     = lkup_index;
      if (sweeping && !cpurst) begin
         btb_tag_cen_b = 1'b0;
         btb_tag_wen   = 4'b0000;
         arr_index     = sweep_cnt_q;
      end else if (lkup_acc) begin
         btb_tag_cen_b = 1'b0;
      end else if (wr_issue) begin
         btb_tag_cen_b        = 1'b0;
         btb_tag_wen[buf_way] = 1'b0;
         arr_index            = buf_index;
         // Ways 0/2 share lane 0, ways 1/3 share lane 1.
         if (buf_way[0])
            btb_tag_din[2*ENT_W-1:ENT_W] = {1'b1, buf_tag};
         else
            btb_tag_din[ENT_W-1:0]       = {1'b1, buf_tag};
      end
   end

   assign btb_index      = 10'(arr_index);
   assign btb_tag_clk_en = ~btb_tag_cen_b;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_q     <= INIT_INV;
         sweep_cnt_q <= '0;
         inv_done_q  <= 1'b0;
         rslt_vld_q  <= 1'b0;
         lkup_tag_q  <= '0;
      end else begin
         inv_done_q <= 1'b0;
         rslt_vld_q <= lkup_acc;
         if (lkup_acc)
            lkup_tag_q <= lkup_tag;
         case (state_q)
            INIT_INV, INV: begin
               if (&sweep_cnt_q) begin
                  state_q     <= IDLE;
                  sweep_cnt_q <= '0;
                  inv_done_q  <= 1'b1;
               end else begin
                  sweep_cnt_q <= sweep_cnt_q + IDX_W'(1);
               end
            end
            IDLE: begin
               if (inv_req) begin
                  state_q     <= INV;
                  sweep_cnt_q <= '0;
               end
            end
            default: begin
               state_q     <= INIT_INV;
               sweep_cnt_q <= '0;
            end
         endcase
      end
   end

   // Tag compare against the data read in the acceptance cycle.
   for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_cmp
      assign hit_way[gi] = rslt_vld_q && btb_tag_dout[gi*ENT_W + ENT_W - 1] &&
                           (btb_tag_dout[gi*ENT_W +: TAG_W] == lkup_tag_q);
   end

   assign rslt_vld     = rslt_vld_q;
   assign rslt_hit_way = hit_way;
   assign rslt_hit     = |hit_way;
   assign inv_busy     = sweeping;
   assign inv_done     = inv_done_q;

endmodule

// File: tb/tb_ct_ifu_btb_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_ifu_btb_tag_ctrl
// Drives the controller one cycle at a time against a behavioural SRAM and a
// reference model that tracks BTB contents per (set, way), the pending
// update, and the invalidate sweep progress.
// ---------------------------------------------------------------------------
module tb_ct_ifu_btb_tag_ctrl;

   localparam int IDX_W = 9;
   localparam int TAG_W = 10;
   localparam int NSETS = 512;

   logic             clk = 1'b0;
   logic             cpurst;
   logic             lkup_vld, lkup_rdy;
   logic [IDX_W-1:0] lkup_index;
   logic [TAG_W-1:0] lkup_tag;
   logic             upd_vld, upd_rdy;
   logic [IDX_W-1:0] upd_index;
   logic [TAG_W-1:0] upd_tag;
   logic [1:0]       upd_way;
   logic             inv_req, inv_busy, inv_done;
   logic             rslt_vld, rslt_hit;
   logic [3:0]       rslt_hit_way;
   logic [9:0]       btb_index;
   logic             btb_tag_cen_b, btb_tag_clk_en;
   logic [21:0]      btb_tag_din;
   logic [3:0]       btb_tag_wen;
   logic [43:0]      btb_tag_dout;

   always #5 clk = ~clk;

   ct_ifu_btb_tag_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
      .forever_cpuclk (clk),
      .cpurst         (cpurst),
      .lkup_vld       (lkup_vld),
      .lkup_index     (lkup_index),
      .lkup_tag       (lkup_tag),
      .lkup_rdy       (lkup_rdy),
      .upd_vld        (upd_vld),
      .upd_index      (upd_index),
      .upd_tag        (upd_tag),
      .upd_way        (upd_way),
      .upd_rdy        (upd_rdy),
      .inv_req        (inv_req),
      .inv_busy       (inv_busy),
      .inv_done       (inv_done),
      .rslt_vld       (rslt_vld),
      .rslt_hit       (rslt_hit),
      .rslt_hit_way   (rslt_hit_way),
      .btb_index      (btb_index),
      .btb_tag_cen_b  (btb_tag_cen_b),
      .btb_tag_clk_en (btb_tag_clk_en),
      .btb_tag_din    (btb_tag_din),
      .btb_tag_wen    (btb_tag_wen),
      .btb_tag_dout   (btb_tag_dout)
   );

   // Behavioural tag SRAM: registered read, per-way active-low write.
   logic [10:0] sram [NSETS][4];
   always @(posedge clk) begin
      if (!btb_tag_cen_b) begin
         for (int w = 0; w < 4; w++) begin
            if (btb_tag_wen == 4'hf)
               btb_tag_dout[w*11 +: 11] <= sram[btb_index[8:0]][w];
            else if (!btb_tag_wen[w])
               sram[btb_index[8:0]][w] <= btb_tag_din[(w%2)*11 +: 11];
         end
      end
   end

   // Reference model state
   bit       m_busy, m_done, m_full, r_vld;
   int       m_cnt, m_idx, m_tag, m_way, m_age;
   bit [3:0] r_way;
   bit       mv [NSETS][4];
   int       mt [NSETS][4];
   int       n_cmp, n_bad;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit lv, input int li, input int lt,
                       input bit uv, input int ui, input int ut, input int uw,
                       input bit ir);
      bit       e_lrdy, e_urdy, acc, issue, load;
      bit [3:0] hw;
      acc = 0; issue = 0; load = 0; hw = '0;
      @(negedge clk);
      cpurst     = rst;
      lkup_vld   = lv;
      lkup_index = li[IDX_W-1:0];
      lkup_tag   = lt[TAG_W-1:0];
      upd_vld    = uv;
      upd_index  = ui[IDX_W-1:0];
      upd_tag    = ut[TAG_W-1:0];
      upd_way    = uw[1:0];
      inv_req    = ir;
      #1;
      if (rst) begin
         check("rst_lkup_rdy", lkup_rdy, 0);
         check("rst_upd_rdy", upd_rdy, 0);
         check("rst_cen_b", btb_tag_cen_b, 1);
         check("rst_wen", btb_tag_wen, 4'hf);
      end else begin
         check("inv_busy", inv_busy, m_busy);
         check("inv_done", inv_done, m_done);
         check("rslt_vld", rslt_vld, r_vld);
         check("rslt_hit_way", rslt_hit_way, r_way);
         check("rslt_hit", rslt_hit, r_way != 0);
         if (m_busy) begin
            check("sweep_lkup_rdy", lkup_rdy, 0);
            check("sweep_upd_rdy", upd_rdy, 0);
            check("sweep_cen_b", btb_tag_cen_b, 0);
            check("sweep_wen", btb_tag_wen, 0);
            check("sweep_index", btb_index, m_cnt);
            check("sweep_din", btb_tag_din, 0);
         end else begin
            e_lrdy = !(m_full && (m_age >= 7 || m_idx == li));
            e_urdy = !m_full;
            acc    = lv && e_lrdy;
            issue  = m_full && !acc;
            load   = uv && e_urdy;
            check("lkup_rdy", lkup_rdy, e_lrdy);
            check("upd_rdy", upd_rdy, e_urdy);
            if (acc) begin
               check("rd_cen_b", btb_tag_cen_b, 0);
               check("rd_wen", btb_tag_wen, 4'hf);
               check("rd_index", btb_index, li);
               for (int w = 0; w < 4; w++)
                  hw[w] = mv[li][w] && (mt[li][w] == lt);
            end else if (issue) begin
               check("wr_cen_b", btb_tag_cen_b, 0);
               check("wr_wen", btb_tag_wen, (~(1 << m_way)) & 4'hf);
               check("wr_index", btb_index, m_idx);
               check("wr_din", btb_tag_din, longint'(1024 | m_tag) << (11 * (m_way % 2)));
            end else begin
               check("idle_cen_b", btb_tag_cen_b, 1);
               check("idle_wen", btb_tag_wen, 4'hf);
            end
         end
         check("clk_en", btb_tag_clk_en, !btb_tag_cen_b);
      end
      @(posedge clk);
      if (rst) begin
         m_busy = 1; m_cnt = 0; m_done = 0; m_full = 0; m_age = 0;
         r_vld = 0; r_way = '0;
      end else if (m_busy) begin
         m_full = 0; m_age = 0; r_vld = 0; r_way = '0;
         m_done = (m_cnt == NSETS - 1);
         if (m_done) begin
            m_busy = 0; m_cnt = 0;
            for (int s = 0; s < NSETS; s++)
               for (int w = 0; w < 4; w++) mv[s][w] = 0;
         end else begin
            m_cnt++;
         end
      end else begin
         m_done = 0;
         r_vld  = acc;
         r_way  = hw;
         if (issue) begin
            mv[m_idx][m_way] = 1;
            mt[m_idx][m_way] = m_tag;
            m_full = 0; m_age = 0;
         end else if (load) begin
            m_full = 1; m_age = 0;
            m_idx = ui; m_tag = ut; m_way = uw;
         end else if (m_full) begin
            m_age++;
         end
         if (ir) begin
            m_busy = 1; m_cnt = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic lk(input int idx, input int tag);
      step(0, 1, idx, tag, 0, 0, 0, 0, 0);
   endtask

   task automatic up(input int idx, input int tag, input int way);
      step(0, 0, 0, 0, 1, idx, tag, way, 0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      cpurst = 1; lkup_vld = 0; lkup_index = '0; lkup_tag = '0;
      upd_vld = 0; upd_index = '0; upd_tag = '0; upd_way = '0; inv_req = 0;
      btb_tag_dout = '0;
      for (int s = 0; s < NSETS; s++)
         for (int w = 0; w < 4; w++) begin
            sram[s][w] = 11'($urandom);
            mv[s][w] = 0; mt[s][w] = 0;
         end
      m_busy = 1; m_cnt = 0; m_done = 0; m_full = 0; m_age = 0;
      m_idx = 0; m_tag = 0; m_way = 0; r_vld = 0; r_way = '0;

      // Power-on sweep
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(514);
      $display("power-on sweep finished, lkup_rdy=%0b", lkup_rdy);

      // Update way 2 of set 5, then look it up (hazard stall, then hit)
      up(5, 'h2A, 2);
      lk(5, 'h2A);
      lk(5, 'h2A);
      idle(1);
      $display("set 5 way 2 lookup: hit=%0b way=%b", rslt_hit, rslt_hit_way);

      // Starvation: buffered update behind continuous lookups
      up(20, 1, 1);
      for (int i = 0; i < 10; i++) lk(3, 0);
      idle(1);
      $display("starvation sequence done, upd_rdy=%0b", upd_rdy);

      // Hazard on set 7
      up(7, 'h15, 3);
      lk(7, 'h15);
      lk(7, 'h15);
      idle(1);
      $display("set 7 hazard lookup: hit=%0b way=%b", rslt_hit, rslt_hit_way);

      // Invalidate after several updates wipes every entry
      for (int i = 0; i < 4; i++) begin
         up(40 + i, 9, i);
         idle(1);
      end
      for (int i = 0; i < 4; i++) lk(40 + i, 9);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(514);
      for (int i = 0; i < 4; i++) lk(40 + i, 9);
      lk(5, 'h2A);
      idle(1);
      $display("post-invalidate lookups done");

      // Reset in the middle of the sweep
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      while (m_cnt != 300) idle(1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(514);
      $display("mid-sweep reset recovery done, inv_busy=%0b", inv_busy);

      // Randomised traffic over a small set/tag space to provoke hits and hazards
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 2999) == 0,
              $urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 9) < 3, $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 3),
              $urandom_range(0, 599) == 0);
      end
      idle(520);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
